// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with an iterative radix-2 multiply/divide engine.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle, then a single fix-up cycle for sign correction and the HI/LO write.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // state | meaning
    // IDLE  | waiting for a request; MTHI/MTLO complete here
    // RUN   | one radix-2 mul/div step per cycle, WIDTH steps
    // FIX   | sign-correct result and write HI/LO
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // Multiply: {partial upper, multiplier shifting out}.
    // Divide:   {remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     m_q, m_d;          // multiplicand or divisor magnitude
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;      // negate product / quotient
    logic                 neg_rem_q, neg_rem_d;
    logic                 div0_q, div0_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 signed_op;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Operand conditioning, per-step datapath and result sign fix-up.
    always_comb begin
        signed_op = ~op_code[0];
        a_abs     = (signed_op && src_a[WIDTH-1]) ? (WIDTH'(0) - src_a) : src_a;
        b_abs     = (signed_op && src_b[WIDTH-1]) ? (WIDTH'(0) - src_b) : src_b;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, m_q};
        prod_fix  = neg_q ? ((2*WIDTH)'(0) - acc_q) : acc_q;
        quo_fix   = div0_q ? {WIDTH{1'b1}}
                  : (neg_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0]);
        rem_fix   = neg_rem_q ? (WIDTH'(0) - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
    end

    // Controller next-state and register updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        m_d       = m_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_valid && !flush) begin
                    if (!op_code[2]) begin
                        is_div_d  = op_code[1];
                        acc_d     = {{WIDTH{1'b0}}, (op_code[1] ? a_abs : b_abs)};
                        m_d       = op_code[1] ? b_abs : a_abs;
                        neg_d     = signed_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        neg_rem_d = signed_op & src_a[WIDTH-1];
                        div0_d    = op_code[1] & (src_b == '0);
                        cnt_d     = '0;
                        state_d   = RUN;
                    end else if (op_code == OP_MTHI) begin
                        hi_d = src_a;
                    end else if (op_code == OP_MTLO) begin
                        lo_d = src_a;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        if (!div_diff[WIDTH])
                            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        else
                            acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1))
                        state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            m_q       <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: 32-bit instance plus an 8-bit build.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, flush;
    logic [2:0]  op_code;
    logic [31:0] src_a, src_b;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        op_valid8;
    logic [2:0]  op_code8;
    logic [7:0]  src_a8, src_b8;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    int vectors = 0;
    int miscompares = 0;
    int lat, bcnt;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    hilo_muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .op_valid(op_valid8), .op_code(op_code8),
        .src_a(src_a8), .src_b(src_b8), .flush(1'b0),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge right after the accept edge; returns at the
    // negedge where done is seen (or after the cycle budget).
    task automatic wait_done(output int l, output int bc);
        int n;
        n  = 1;
        bc = 0;
        while (done !== 1'b1 && n < 200) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        l = n - 1;
    endtask

    // Called at a negedge; issues a one-cycle request then waits for done.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int l, output int bc);
        op_valid = 1'b1; op_code = op; src_a = a; src_b = b;
        @(negedge clk);
        op_valid = 1'b0;
        wait_done(l, bc);
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] d);
        op_valid = 1'b1; op_code = op; src_a = d;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; op_valid = 1'b0; flush = 1'b0; op_code = 3'd0; src_a = '0; src_b = '0;
        op_valid8 = 1'b0; op_code8 = 3'd0; src_a8 = '0; src_b8 = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // MULT -3 * 7
        run_op(3'd0, 32'hFFFFFFFD, 32'd7, lat, bcnt);
        check("mult_latency", lat, 33);
        check("mult_busy_cycles", bcnt, 33);
        check("mult_busy_at_done", busy, 1'b0);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFEB);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);

        // MULTU max*max, then DIV -7/2 issued in the done cycle
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, lat, bcnt);
        check("b2b_div_latency", lat, 33);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        // Divide by zero and signed overflow
        run_op(3'd3, 32'd100, 32'd0, lat, bcnt);
        check("divu0_lo", lo, 32'hFFFFFFFF);
        check("divu0_hi", hi, 32'h00000064);
        check("divu0_latency", lat, 33);
        run_op(3'd2, 32'hFFFFFFF9, 32'd0, lat, bcnt);
        check("div0_neg_lo", lo, 32'hFFFFFFFF);
        check("div0_neg_hi", hi, 32'hFFFFFFF9);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
        check("divovf_lo", lo, 32'h80000000);
        check("divovf_hi", hi, 32'h00000000);
        run_op(3'd3, 32'd100, 32'd7, lat, bcnt);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // MTHI then MTLO on consecutive cycles
        op_valid = 1'b1; op_code = 3'd4; src_a = 32'h12345678;
        @(negedge clk);
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_busy", busy, 1'b0);
        op_code = 3'd5; src_a = 32'h9ABCDEF0;
        @(negedge clk);
        op_valid = 1'b0;
        check("mtlo_lo", lo, 32'h9ABCDEF0);
        check("mtlo_hi_kept", hi, 32'h12345678);
        check("mt_busy", busy, 1'b0);
        check("mt_done", done, 1'b0);

        // No-op code leaves HI/LO alone
        op_valid = 1'b1; op_code = 3'd6; src_a = 32'h0; src_b = 32'h0;
        @(negedge clk);
        op_valid = 1'b0;
        check("noop_busy", busy, 1'b0);
        check("noop_hi", hi, 32'h12345678);

        // MTHI while busy is ignored
        op_valid = 1'b1; op_code = 3'd1; src_a = 32'd6; src_b = 32'd7;
        @(negedge clk);
        op_code = 3'd4; src_a = 32'h0000DEAD;
        @(negedge clk);
        op_valid = 1'b0;
        check("mthi_busy_ignored", hi, 32'h12345678);
        check("busy_during_run", busy, 1'b1);
        wait_done(lat, bcnt);
        check("multu67_lo", lo, 32'h0000002A);
        check("multu67_hi", hi, 32'h00000000);

        // Flush together with op_valid in IDLE suppresses MTHI
        flush = 1'b1;
        mt(3'd4, 32'h55555555);
        flush = 1'b0;
        check("flush_idle_mthi", hi, 32'h00000000);

        // Flush at RUN step 10
        mt(3'd4, 32'd1);
        mt(3'd5, 32'd2);
        op_valid = 1'b1; op_code = 3'd3; src_a = 32'd100; src_b = 32'd3;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_run_busy", busy, 1'b0);
        check("flush_run_done", done, 1'b0);
        check("flush_run_hi", hi, 32'd1);
        check("flush_run_lo", lo, 32'd2);
        repeat (30) @(negedge clk);
        check("flush_run_no_late_done", done, 1'b0);
        check("flush_run_hi_late", hi, 32'd1);

        // Flush in the FIX cycle
        op_valid = 1'b1; op_code = 3'd3; src_a = 32'd100; src_b = 32'd3;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (32) @(negedge clk);
        check("fix_busy_before_flush", busy, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_fix_busy", busy, 1'b0);
        check("flush_fix_done", done, 1'b0);
        check("flush_fix_hi", hi, 32'd1);
        check("flush_fix_lo", lo, 32'd2);

        // Asynchronous reset mid-multiply
        op_valid = 1'b1; op_code = 3'd0; src_a = 32'd1234; src_b = 32'd5678;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_hi", hi, 32'h0);
        check("arst_lo", lo, 32'h0);
        check("arst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("arst_no_done", done, 1'b0);
        run_op(3'd1, 32'd6, 32'd7, lat, bcnt);
        check("post_rst_lo", lo, 32'h0000002A);
        check("post_rst_hi", hi, 32'h00000000);

        // 8-bit build: MULT 0x80 * 0x80
        begin
            int n;
            op_valid8 = 1'b1; op_code8 = 3'd0; src_a8 = 8'h80; src_b8 = 8'h80;
            @(negedge clk);
            op_valid8 = 1'b0;
            n = 1;
            while (done8 !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("w8_latency", n - 1, 9);
            check("w8_hi", hi8, 8'h40);
            check("w8_lo", lo8, 8'h00);
            check("w8_busy_at_done", busy8, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Parametrised, iterative multiply/divide unit that owns the HI/LO register pair for the MIPS pipeline.
- Replaces fixed-width HI/LO handling in the execute stage.
- Supports signed and unsigned MULT and DIV, plus MTHI and MTLO.
- Exposes a busy level that the hazard logic uses to stall the pipeline, and accepts an execute-stage flush that cancels an in-flight operation.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- op_valid  in  1  request qualifier; sampled only in IDLE.
- op_code  in  3  operation select: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are no-ops.
- src_a  in  WIDTH  multiplicand, dividend, or MTHI/MTLO data.
- src_b  in  WIDTH  multiplier or divisor.
- flush  in  1  cancels any accepted or in-flight operation.
- busy  out  1  high while a mul/div is in flight; pipeline stall request.
- done  out  1  one-cycle pulse: HI/LO updated by a mul/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst=0, any time, including mid-operation):
  - state=IDLE; hi=0, lo=0, busy=0, done=0; counter and datapath registers cleared.
  - Takes effect immediately.
- States: IDLE, RUN, FIX.
  - busy = (state != IDLE), decoded from registered state, with no combinational path from inputs.
  - done is registered.
- IDLE with op_valid=1 and flush=0:
  - MULT, MULTU, DIV, DIVU: latch absolute operand values (signed ops) or raw values (unsigned ops), latch the result sign flags, set counter=0, go to RUN.
  - MTHI: hi<=src_a. MTLO: lo<=src_a. Stay in IDLE; busy and done stay low.
  - op_code 6 or 7: ignored.
- op_valid is ignored outside IDLE. The controller must stall while busy.
- RUN:
  - One radix-2 step per cycle; counter increments each cycle.
  - Multiply: shift-add into a 2*WIDTH product register.
  - Divide: restoring shift-subtract, producing a WIDTH quotient and WIDTH remainder.
  - After WIDTH steps (counter == WIDTH-1 at the edge), go to FIX.
- FIX (1 cycle), at the edge leaving FIX:
  - Sign-correct the result and write hi/lo; done<=1 for exactly one cycle; state<=IDLE.
  - Product: hi=upper half, lo=lower half; negated (two's complement, 2*WIDTH) if operand signs differ (MULT only).
  - Quotient: lo; negated if signs differ (DIV only).
  - Remainder: hi; takes the sign of the dividend (DIV only).
- Latency:
  - Request sampled at edge E0.
  - busy is high in cycles E0+1 through E0+WIDTH+1.
  - hi/lo are updated at edge E0+WIDTH+1.
  - done and the new hi/lo are visible in the cycle after E0+WIDTH+1, with busy=0 in that same cycle.
  - Total WIDTH+1 edges; 33 at default.
- A new request may be accepted in the cycle done is high (back-to-back operation).
- Divide by zero (src_b=0):
  - lo = all ones; hi = dividend (original src_a, signed or unsigned).
  - Normal latency; no exception.
- Signed overflow (DIV MIN/-1): lo=MIN, hi=0. This falls out of the absolute-value algorithm.
- Flush:
  - In RUN or FIX: state<=IDLE next edge; hi/lo unchanged; done stays 0.
  - In the FIX cycle, flush wins over the hi/lo write.
  - Flush in IDLE together with op_valid: request not accepted; MTHI/MTLO also suppressed.
- hi/lo change only via MTHI, MTLO, mul/div completion, or reset.

Test Plan:
- WIDTH=32, MULT src_a=FFFFFFFD (-3), src_b=7 -> done 33 edges after accept; hi=FFFFFFFF, lo=FFFFFFEB; busy high exactly 33 cycles.
- MULTU FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Then immediately DIV FFFFFFF9 (-7) / 2, issued during the done cycle -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU 00000064 / 0 -> lo=FFFFFFFF, hi=00000064. DIV 80000000 / FFFFFFFF -> lo=80000000, hi=00000000.
- MTHI 12345678 then MTLO 9ABCDEF0 on consecutive cycles -> hi/lo visible the following cycle; busy and done never assert. MTHI issued while busy -> hi unchanged.
- Preload hi=1, lo=2; start DIVU 100/3; assert flush at RUN step 10 -> busy low next cycle, no done, hi=1, lo=2. Repeat with flush in the FIX cycle -> same result.
- Start MULT, drop rst for one cycle at step 5 -> hi=lo=0, busy=0 immediately. After release, MULTU 6 x 7 -> lo=0000002A, hi=0.
- WIDTH=8 build: MULT 80 x 80 -> hi=40, lo=00; done 9 edges after accept.
